// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
package pipe_pkg;

    // Default bundle and counter widths for a standard stage instance
    localparam int unsigned CTRL_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned CNT_W_DEF  = 16;

    // Canonical RISC-V NOP (addi x0, x0, 0); the IF/ID instance flushes to this
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Bit positions inside the control bundle
    localparam int unsigned CTRL_REG_WRITE  = 0;
    localparam int unsigned CTRL_MEM_READ   = 1;
    localparam int unsigned CTRL_MEM_WRITE  = 2;
    localparam int unsigned CTRL_BRANCH     = 3;
    localparam int unsigned CTRL_IS_VECTOR  = 4;
    localparam int unsigned CTRL_JUMP       = 5;
    localparam int unsigned CTRL_MEM_TO_REG = 6;
    localparam int unsigned CTRL_ALU_SRC    = 7;

    // Occupancy state; the encoding equals the number of held entries
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    // Number of entries held in a given state
    function automatic logic [1:0] state_occupancy(input pipe_state_e st);
        logic [1:0] occ;
        case (st)
            ST_ONE:  occ = 2'd1;
            ST_TWO:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    // Next count: clear, else increment unless already saturated
    always_comb begin
        w_count_nxt = r_count;
        if (i_clr) begin
            w_count_nxt = '0;
        end else if (i_inc && (r_count != CNT_MAX)) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, two-entry skid buffer,
// flush with bubble injection and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        CTRL_W     = 8,
    parameter int unsigned        DATA_W     = 64,
    parameter logic [DATA_W-1:0]  FLUSH_DATA = '0,
    parameter int unsigned        CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    // Held state
    pipe_state_e       r_state;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [1:0]        r_occupancy;

    // Next-state values
    pipe_state_e       w_state_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic              w_in_ready_nxt;
    logic              w_out_valid_nxt;
    logic [1:0]        w_occupancy_nxt;

    logic              w_acc;
    logic              w_drn;
    logic              w_stall;

    // Handshakes use registered ready/valid only, so no out_ready -> in_ready path
    assign w_acc   = in_valid && r_in_ready;
    assign w_drn   = r_out_valid && out_ready;
    assign w_stall = r_out_valid && !out_ready;

    // Next-state and next-output decode; flush overrides every transition
    always_comb begin
        w_state_nxt     = r_state;
        w_main_ctrl_nxt = r_main_ctrl;
        w_main_data_nxt = r_main_data;
        w_skid_ctrl_nxt = r_skid_ctrl;
        w_skid_data_nxt = r_skid_data;

        if (flush) begin
            w_state_nxt     = ST_EMPTY;
            w_main_ctrl_nxt = '0;
            w_main_data_nxt = FLUSH_DATA;
            w_skid_ctrl_nxt = '0;
            w_skid_data_nxt = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt     = ST_ONE;
                        w_main_ctrl_nxt = in_ctrl;
                        w_main_data_nxt = in_data;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_drn) begin
                        w_main_ctrl_nxt = in_ctrl;
                        w_main_data_nxt = in_data;
                    end else if (w_acc) begin
                        w_state_nxt     = ST_TWO;
                        w_skid_ctrl_nxt = in_ctrl;
                        w_skid_data_nxt = in_data;
                    end else if (w_drn) begin
                        // Data lane keeps its last value; ctrl zeroed so the bubble is a NOP
                        w_state_nxt     = ST_EMPTY;
                        w_main_ctrl_nxt = '0;
                    end
                end
                ST_TWO: begin
                    if (w_drn) begin
                        w_state_nxt     = ST_ONE;
                        w_main_ctrl_nxt = r_skid_ctrl;
                        w_main_data_nxt = r_skid_data;
                        w_skid_ctrl_nxt = '0;
                        w_skid_data_nxt = '0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage
                    w_state_nxt     = ST_EMPTY;
                    w_main_ctrl_nxt = '0;
                    w_skid_ctrl_nxt = '0;
                    w_skid_data_nxt = '0;
                end
            endcase
        end

        w_in_ready_nxt  = (w_state_nxt != ST_TWO);
        w_out_valid_nxt = (w_state_nxt != ST_EMPTY);
        w_occupancy_nxt = state_occupancy(w_state_nxt);
    end

    // State, payload and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occupancy <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_main_data <= w_main_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_occupancy <= w_occupancy_nxt;
        end
    end

    // Back-pressure cycle counter
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_inc   (w_stall),
        .i_clr   (stall_clr),
        .o_count (stall_cnt)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;
    assign occupancy = r_occupancy;

endmodule
